shadow_cst_gen: RTL

SHADOW_CST_GEN -- requirements
Module: shadow_cst_gen

---
 rtl/shadow_cst_gen.sv | 106 ++++++++++
 1 files changed

// File: rtl/shadow_cst_gen.sv
// shadow_cst_gen
//   Issues a run of NSTEPS 128-bit round constants over a valid/ready
//   handshake. Each run starts from SEED; every accepted constant advances
//   the state by rotating the four 32-bit words down one place and inserting
//   xtime(w0) as the new top word. A one-cycle done pulse follows the
//   acceptance of the final constant.
//
// Ports
//   clk        in   1    clock, rising edge
//   rst_n      in   1    synchronous active-low reset
//   start      in   1    begin a new run (honoured only while idle)
//   busy       out  1    run in progress
//   cst_valid  out  1    cst holds a valid constant
//   cst_ready  in   1    downstream accepts cst this cycle
//   cst        out  128  current constant {w3,w2,w1,w0}
//   cst_idx    out  4    index of the constant on cst
//   cst_last   out  1    cst is the final constant of the run
//   done       out  1    one-cycle pulse after the final transfer
module shadow_cst_gen #(
    parameter int unsigned  NSTEPS = 12,
    parameter logic [127:0] SEED   = 128'h00000000_00000000_00000000_00000001
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic         cst_valid,
    input  logic         cst_ready,
    output logic [127:0] cst,
    output logic [3:0]   cst_idx,
    output logic         cst_last,
    output logic         done
);

    localparam logic [3:0] LAST_IDX = 4'(NSTEPS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // GF(2^8)-style doubling applied to a full 32-bit word: the carried-out
    // top bit is folded back in at bits 0 and 8.
    function automatic logic [31:0] xtime(input logic [31:0] x);
        return {x[30:0], 1'b0} ^ {31'b0, x[31]} ^ {23'b0, x[31], 8'b0};
    endfunction

    state_t        state_q;
    logic [127:0]  cst_q;
    logic [127:0]  cst_d;
    logic [3:0]    idx_q;
    logic [3:0]    idx_d;
    logic          last_q;
    logic          done_q;

    // Successor constant: w0<=w1, w1<=w2, w2<=w3, w3<=xt(w0).
    always_comb begin
        cst_d = {xtime(cst_q[31:0]), cst_q[127:32]};
        idx_d = idx_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cst_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        cst_q   <= SEED;
                        idx_q   <= '0;
                        last_q  <= (NSTEPS == 1);
                    end
                end
                RUN: begin
                    if (cst_ready) begin
                        if (idx_q == LAST_IDX) begin
                            // Final constant accepted: hold cst/idx, pulse done.
                            state_q <= IDLE;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cst_q  <= cst_d;
                            idx_q  <= idx_d;
                            last_q <= (idx_d == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == RUN);
    assign cst_valid = (state_q == RUN);
    assign cst       = cst_q;
    assign cst_idx   = idx_q;
    assign cst_last  = last_q;
    assign done      = done_q;

endmodule
